// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_DEAD,
    ST_DRIVE
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_ERR = 7'b0001001;

  // Active-low {g,f,e,d,c,b,a} patterns indexed by nibble value; A..F show the error glyph.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR, SEG_ERR,
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// Combinational nibble to active-low 7-segment decoder.
module seg_nibble_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// Optional feature: define SEG_LZB_EN to enable leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CLK_DIV    = 100000
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iEn,
  input  logic                      iLoad,
  input  logic [4*NUM_DIGITS-1:0]   iData,
  input  logic [NUM_DIGITS-1:0]     iBlank,
  output logic [NUM_DIGITS-1:0]     oAn,
  output logic [6:0]                oSeg,
  output logic                      oFrame
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned PRE_W = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 2);

  scan_state_t                     state, state_d;
  logic [IDX_W-1:0]                idx, idx_d;
  logic [PRE_W-1:0]                presc, presc_d;
  logic [NUM_DIGITS-1:0][3:0]      shadow_data;
  logic [NUM_DIGITS-1:0]           shadow_blank;
  logic [NUM_DIGITS-1:0]           blank_eff;
  logic [3:0]                      cur_nibble;
  logic [6:0]                      dec_seg;
  logic [NUM_DIGITS-1:0]           an_d;
  logic [6:0]                      seg_d;
  logic                            frame_d;

  // Shadow copy of the display value, captured on the load strobe in any state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shadow_data  <= '0;
      shadow_blank <= '0;
    end else if (iLoad) begin
      shadow_data  <= iData;
      shadow_blank <= iBlank;
    end
  end

`ifdef SEG_LZB_EN
  logic [NUM_DIGITS-1:0] lzb_mask;
  logic                  upper_zero;

  // Digit k is suppressed when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    lzb_mask   = '0;
    upper_zero = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero & (shadow_data[i] == 4'h0);
      lzb_mask[i] = upper_zero;
    end
  end

  assign blank_eff = shadow_blank | lzb_mask;
`else
  assign blank_eff = shadow_blank;
`endif

  // Scan state, digit index and slot prescaler.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= ST_OFF;
      idx   <= '0;
      presc <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      presc <= presc_d;
    end
  end

  // Next-state logic; disable overrides every other transition.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    presc_d = presc;
    if (!iEn) begin
      state_d = ST_OFF;
      idx_d   = '0;
      presc_d = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_d = ST_DEAD;
          idx_d   = '0;
          presc_d = '0;
        end
        ST_DEAD: begin
          state_d = ST_DRIVE;
          presc_d = '0;
        end
        ST_DRIVE: begin
          if (presc == PRE_LAST) begin
            state_d = ST_DEAD;
            presc_d = '0;
            idx_d   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            presc_d = presc + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they change on the same edge
  // as the state; the shadow is read as currently held, which gives the one-cycle load latency.
  assign cur_nibble = shadow_data[idx_d];

  seg_nibble_dec u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Anode/segment/frame values for the cycle following the next edge.
  always_comb begin
    an_d    = '1;
    seg_d   = SEG_OFF;
    frame_d = (state_d == ST_DRIVE) && (idx_d == IDX_LAST) && (presc_d == PRE_LAST);
    if (state_d == ST_DRIVE && !blank_eff[idx_d]) begin
      an_d[idx_d] = 1'b0;
      seg_d       = dec_seg;
    end
  end

  // Output registers; reset forces the display dark without waiting for a clock.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oAn    <= '1;
      oSeg   <= SEG_OFF;
      oFrame <= 1'b0;
    end else begin
      oAn    <= an_d;
      oSeg   <= seg_d;
      oFrame <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NUM_DIGITS=4, CLK_DIV=4).
module tb_seg_scan_ctrl;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;
  } exp_t;

  localparam exp_t DARK = '{an: 4'hF, seg: 7'h7F, frame: 1'b0};

  logic        iClk;
  logic        iRst_n;
  logic        iEn;
  logic        iLoad;
  logic [15:0] iData;
  logic [3:0]  iBlank;
  logic [3:0]  oAn;
  logic [6:0]  oSeg;
  logic        oFrame;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  exp_t        exp_q[$];

  seg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iEn    (iEn),
    .iLoad  (iLoad),
    .iData  (iData),
    .iBlank (iBlank),
    .oAn    (oAn),
    .oSeg   (oSeg),
    .oFrame (oFrame)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'd0: ref_seg = 7'b1000000;
      4'd1: ref_seg = 7'b1111001;
      4'd2: ref_seg = 7'b0100100;
      4'd3: ref_seg = 7'b0110000;
      4'd4: ref_seg = 7'b0011001;
      4'd5: ref_seg = 7'b0010010;
      4'd6: ref_seg = 7'b0000010;
      4'd7: ref_seg = 7'b1111000;
      4'd8: ref_seg = 7'b0000000;
      4'd9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b0001001;
    endcase
  endfunction

  // pos 0 is the dead cycle of a slot, pos 1..3 the drive cycles.
  function automatic exp_t ref_entry(input logic [15:0] data, input logic [3:0] blank,
                                     input int slot, input int pos);
    exp_t e;
    logic dark;
    e = DARK;
    if (pos != 0) begin
      dark = blank[slot];
`ifdef SEG_LZB_EN
      if (slot != 0) begin
        logic all_zero;
        all_zero = 1'b1;
        for (int k = slot; k < 4; k++)
          if (data[4*k +: 4] != 4'h0) all_zero = 1'b0;
        if (all_zero) dark = 1'b1;
      end
`endif
      if (!dark) begin
        e.an  = ~(4'b0001 << slot);
        e.seg = ref_seg(data[4*slot +: 4]);
      end
      e.frame = (slot == 3) && (pos == 3);
    end
    return e;
  endfunction

  // Entries before `split` use value A, the rest value B.
  task automatic push_frame(input logic [15:0] a_data, input logic [3:0] a_blank,
                            input logic [15:0] b_data, input logic [3:0] b_blank,
                            input int split);
    for (int i = 0; i < 16; i++) begin
      if (i < split) exp_q.push_back(ref_entry(a_data, a_blank, i / 4, i % 4));
      else           exp_q.push_back(ref_entry(b_data, b_blank, i / 4, i % 4));
    end
  endtask

  task automatic push_dark(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DARK);
  endtask

  task automatic run_cycles(input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge iClk);
      if (exp_q.size() == 0) begin
        check_eq({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq(tag, {20'd0, oAn, oSeg, oFrame}, {20'd0, e});
      end
    end
  endtask

  task automatic start_scan(input logic [15:0] data, input logic [3:0] blank);
    iData  = data;
    iBlank = blank;
    iLoad  = 1'b1;
    iEn    = 1'b1;
    @(posedge iClk);
    #1 iLoad = 1'b0;
  endtask

  task automatic stop_scan();
    iEn = 1'b0;
    exp_q.delete();
    push_dark(2);
    run_cycles(2, "off");
  endtask

  initial begin
    iRst_n = 1'b1;
    iEn    = 1'b0;
    iLoad  = 1'b0;
    iData  = '0;
    iBlank = '0;
    #1 iRst_n = 1'b0;
    #1 check_eq("reset_async", {20'd0, oAn, oSeg, oFrame}, {20'd0, DARK});
    repeat (2) @(negedge iClk);
    check_eq("reset_held", {20'd0, oAn, oSeg, oFrame}, {20'd0, DARK});
    iRst_n = 1'b1;
    push_dark(2);
    run_cycles(2, "idle_off");

    // Basic scan, two frames to cover index wrap.
    push_frame(16'h1234, 4'b0000, 16'h1234, 4'b0000, 16);
    push_frame(16'h1234, 4'b0000, 16'h1234, 4'b0000, 16);
    start_scan(16'h1234, 4'b0000);
    run_cycles(32, "scan");
    stop_scan();

    // Error glyphs for A..F.
    push_frame(16'hFA0C, 4'b0000, 16'hFA0C, 4'b0000, 16);
    start_scan(16'hFA0C, 4'b0000);
    run_cycles(16, "err_glyph");
    stop_scan();

    // Blank mask keeps slot timing.
    push_frame(16'h1234, 4'b0100, 16'h1234, 4'b0100, 16);
    start_scan(16'h1234, 4'b0100);
    run_cycles(16, "blank");
    stop_scan();

    // Load during a drive slot: visible one edge after the shadow update.
    push_frame(16'h1234, 4'b0000, 16'h8765, 4'b0000, 3);
    start_scan(16'h1234, 4'b0000);
    run_cycles(2, "midload");
    iData = 16'h8765;
    iLoad = 1'b1;
    run_cycles(1, "midload");
    iLoad = 1'b0;
    run_cycles(13, "midload");
    stop_scan();

    // Asynchronous reset in the middle of slot 2.
    push_frame(16'h1234, 4'b0000, 16'h1234, 4'b0000, 16);
    start_scan(16'h1234, 4'b0000);
    run_cycles(10, "pre_reset");
    #2 iRst_n = 1'b0;
    #1 check_eq("reset_midslot", {20'd0, oAn, oSeg, oFrame}, {20'd0, DARK});
    exp_q.delete();
    @(negedge iClk);
    iRst_n = 1'b1;
    push_frame(16'h0000, 4'b0000, 16'h0000, 4'b0000, 16);
    run_cycles(16, "post_reset");
    stop_scan();

    // Disable mid-slot 1, re-enable restarts at digit 0.
    push_frame(16'h1234, 4'b0000, 16'h1234, 4'b0000, 16);
    start_scan(16'h1234, 4'b0000);
    run_cycles(6, "pre_dis");
    iEn = 1'b0;
    exp_q.delete();
    push_dark(1);
    run_cycles(1, "disable");
    iEn = 1'b1;
    push_frame(16'h1234, 4'b0000, 16'h1234, 4'b0000, 16);
    run_cycles(16, "reenable");

    // Load coinciding with disable is still captured.
    iEn   = 1'b0;
    iLoad = 1'b1;
    iData = 16'h4321;
    exp_q.delete();
    push_dark(2);
    run_cycles(1, "load_off");
    iLoad = 1'b0;
    run_cycles(1, "load_off");
    iEn = 1'b1;
    push_frame(16'h4321, 4'b0000, 16'h4321, 4'b0000, 16);
    run_cycles(16, "load_off_scan");
    stop_scan();

    // Leading zeros (blanked only when SEG_LZB_EN is defined).
    push_frame(16'h0050, 4'b0000, 16'h0050, 4'b0000, 16);
    start_scan(16'h0050, 4'b0000);
    run_cycles(16, "lzb");
    stop_scan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
